// File: rtl/jtopl_eg_stepper_pkg.sv
// Shared envelope-step definitions: slot state encoding, rate saturation and
// the step patterns indexed by the 3-bit counter tap.
package jtopl_eg_stepper_pkg;

  typedef enum logic [1:0] {
    ATTACK  = 2'd0,
    DECAY   = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } eg_state_e;

  localparam logic [6:0] RATE_SAT = 7'd60;

  localparam logic [7:0] PAT_00 = 8'h00;
  localparam logic [7:0] PAT_88 = 8'h88;
  localparam logic [7:0] PAT_AA = 8'hAA;
  localparam logic [7:0] PAT_EA = 8'hEA;
  localparam logic [7:0] PAT_EE = 8'hEE;
  localparam logic [7:0] PAT_FE = 8'hFE;
  localparam logic [7:0] PAT_FF = 8'hFF;

  // Attenuation increment per step: 1 below rate 48, then 2/4/8/16 per rate group.
  function automatic logic [4:0] eg_inc(input logic [5:0] rate);
    if (rate < 6'd48) return 5'd1;
    return 5'd1 << (rate[5:2] - 4'd11);
  endfunction

endpackage

// File: rtl/jtopl_eg_stepper_if.sv
// Slot-side bundle between the per-slot register file (master) and the
// envelope step engine (slave).
interface jtopl_eg_stepper_if #(
  parameter int SLOTS = 18,
  parameter int CNTW  = 15,
  parameter int EGW   = 9
);
  localparam int SW = $clog2(SLOTS);

  logic            cen;
  logic [1:0]      eg_state;
  logic [4:0]      base_rate;
  logic [3:0]      keycode;
  logic            ksr;
  logic [EGW-1:0]  eg_in;
  logic [SW-1:0]   slot;
  logic            zero;
  logic [CNTW-1:0] eg_cnt;
  logic [SW-1:0]   out_slot;
  logic [5:0]      rate;
  logic            step;
  logic [EGW-1:0]  eg_out;
  logic            out_valid;

  modport master (
    output cen, eg_state, base_rate, keycode, ksr, eg_in,
    input  slot, zero, eg_cnt, out_slot, rate, step, eg_out, out_valid
  );

  modport slave (
    input  cen, eg_state, base_rate, keycode, ksr, eg_in,
    output slot, zero, eg_cnt, out_slot, rate, step, eg_out, out_valid
  );
endinterface

// File: rtl/jtopl_eg_rate.sv
// Effective rate, envelope-counter tap and raw step bit for one slot.
// Purely combinational; the caller qualifies the raw bit with edge freshness.
module jtopl_eg_rate
  import jtopl_eg_stepper_pkg::*;
(
  input  logic        attack,
  input  logic [4:0]  base_rate,
  input  logic [3:0]  keycode,
  input  logic        ksr,
  input  logic [13:0] eg_cnt,
  output logic [5:0]  rate,
  output logic [2:0]  cnt3,
  output logic        raw
);
  logic [6:0] pre;
  logic [4:0] sel;
  logic [7:0] pat;

  always_comb begin
    pre = '0;
    if (base_rate != 5'd0)
      pre = {1'b0, base_rate, 1'b0} + (ksr ? {3'b0, keycode} : {5'b0, keycode[3:2]});
    rate = (pre >= RATE_SAT) ? 6'd63 : pre[5:0];

    // Faster rates tap lower counter bits; attack runs one group faster.
    sel  = {1'b0, rate[5:2]} + {4'b0, attack};
    cnt3 = (sel <= 5'd11) ? 3'(eg_cnt >> (5'd11 - sel)) : eg_cnt[2:0];

    if (rate[5:4] == 2'b11) begin
      if (attack && rate[5:2] == 4'd15) pat = PAT_FF;
      else begin
        case (rate[1:0])
          2'd0:    pat = PAT_00;
          2'd1:    pat = PAT_88;
          2'd2:    pat = PAT_AA;
          default: pat = PAT_EE;
        endcase
      end
    end else begin
      if (!attack && rate[5:2] == 4'd0) pat = PAT_FE;
      else begin
        case (rate[1:0])
          2'd0:    pat = PAT_AA;
          2'd1:    pat = PAT_EA;
          2'd2:    pat = PAT_EE;
          default: pat = PAT_FE;
        endcase
      end
    end

    raw = (rate[5:1] == 5'd0) ? 1'b0 : pat[cnt3];
  end
endmodule

// File: rtl/jtopl_eg_stepper.sv
// Envelope step engine: global envelope counter, round-robin slot counter,
// per-slot tap-LSB history and a 2-stage attenuation update pipeline.
module jtopl_eg_stepper
  import jtopl_eg_stepper_pkg::*;
#(
  parameter int SLOTS = 18,
  parameter int CNTW  = 15,
  parameter int EGW   = 9,
  parameter int PRESC = 1
) (
  input logic clk,
  input logic rst,
  jtopl_eg_stepper_if.slave bus
);
  localparam int SW = $clog2(SLOTS);
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int XW = EGW + 5;

  logic [SW-1:0]    slot_q;
  logic [CNTW-1:0]  cnt_q;
  logic [PW-1:0]    presc_q;
  logic [SLOTS-1:0] lsb_mem;

  logic [5:0]     s1_rate;
  logic           s1_step, s1_attack, s1_valid;
  logic [EGW-1:0] s1_eg;
  logic [SW-1:0]  s1_slot;

  logic [5:0]     rate_q;
  logic           step_q, valid_q;
  logic [EGW-1:0] eg_q;
  logic [SW-1:0]  oslot_q;

  logic           attack_c, raw_c, wrap;
  logic [5:0]     rate_c;
  logic [2:0]     cnt3_c;

  assign attack_c = (bus.eg_state == ATTACK);
  assign wrap     = (slot_q == SW'(SLOTS - 1));

  jtopl_eg_rate u_rate (
    .attack    (attack_c),
    .base_rate (bus.base_rate),
    .keycode   (bus.keycode),
    .ksr       (bus.ksr),
    .eg_cnt    (cnt_q[13:0]),
    .rate      (rate_c),
    .cnt3      (cnt3_c),
    .raw       (raw_c)
  );

  logic [4:0]     inc;
  logic [XW-1:0]  ext, prod, dec, sum, eg_max;
  logic [EGW-1:0] eg_next;

  always_comb begin
    inc     = eg_inc(s1_rate);
    ext     = XW'(s1_eg);
    prod    = ext * XW'(inc);
    dec     = (prod >> 3) + XW'(1);
    sum     = ext + XW'(inc);
    eg_max  = XW'({EGW{1'b1}});
    eg_next = s1_eg;
    if (s1_step) begin
      if (s1_attack) begin
        if ({1'b0, s1_rate} >= RATE_SAT) eg_next = '0;
        else if (ext >= dec)             eg_next = EGW'(ext - dec);
        else                             eg_next = '0;
      end else begin
        eg_next = (sum > eg_max) ? {EGW{1'b1}} : EGW'(sum);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q    <= '0;
      cnt_q     <= '0;
      presc_q   <= '0;
      lsb_mem   <= '0;
      s1_rate   <= '0;
      s1_step   <= 1'b0;
      s1_attack <= 1'b0;
      s1_valid  <= 1'b0;
      s1_eg     <= '0;
      s1_slot   <= '0;
      rate_q    <= '0;
      step_q    <= 1'b0;
      valid_q   <= 1'b0;
      eg_q      <= '0;
      oslot_q   <= '0;
    end else if (bus.cen) begin
      slot_q <= wrap ? '0 : slot_q + SW'(1);
      // Counter advance lands on the wrap edge, so slot 0 of the next sample sees it.
      if (wrap) begin
        if (presc_q == PW'(PRESC - 1)) begin
          presc_q <= '0;
          cnt_q   <= cnt_q + CNTW'(1);
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end

      lsb_mem[slot_q] <= cnt3_c[0];
      s1_rate   <= rate_c;
      s1_step   <= raw_c & (cnt3_c[0] != lsb_mem[slot_q]);
      s1_eg     <= bus.eg_in;
      s1_attack <= attack_c;
      s1_slot   <= slot_q;
      s1_valid  <= 1'b1;

      rate_q  <= s1_rate;
      step_q  <= s1_step;
      eg_q    <= eg_next;
      oslot_q <= s1_slot;
      valid_q <= s1_valid;
    end
  end

  assign bus.slot      = slot_q;
  assign bus.zero      = (slot_q == '0);
  assign bus.eg_cnt    = cnt_q;
  assign bus.out_slot  = oslot_q;
  assign bus.rate      = rate_q;
  assign bus.step      = step_q;
  assign bus.eg_out    = eg_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_jtopl_eg_stepper.sv
// Directed bench for jtopl_eg_stepper: a default 18-slot instance for the
// datapath and a tiny 2-slot, PRESC=2 instance for counter wrap.
module tb_jtopl_eg_stepper;
  import jtopl_eg_stepper_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtopl_eg_stepper_if bus ();
  jtopl_eg_stepper_if #(.SLOTS(2), .CNTW(14), .EGW(9)) bus2 ();

  jtopl_eg_stepper dut (.clk(clk), .rst(rst), .bus(bus));
  jtopl_eg_stepper #(.SLOTS(2), .CNTW(14), .EGW(9), .PRESC(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int errors = 0;
  int checks = 0;
  int ncen   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.cen && !rst) ncen++;
  endtask

  task automatic drive(input logic [1:0] st, input logic [4:0] br, input logic [3:0] kc,
                       input logic k, input logic [8:0] e);
    bus.eg_state  = st;
    bus.base_rate = br;
    bus.keycode   = kc;
    bus.ksr       = k;
    bus.eg_in     = e;
  endtask

  task automatic idle();
    drive(DECAY, 5'd0, 4'd0, 1'b0, 9'd0);
  endtask

  // Advance until the modelled eg_cnt matches (mask,val) and slot == s.
  task automatic wait_pos(input int mask, input int val, input int s);
    int n = 0;
    idle();
    while (!((((ncen / 18) & mask) == val) && (ncen % 18 == s)) && n < 40000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 40000) begin errors++; $display("FAIL wait_pos timeout: ncen=%0d want cnt&%0h=%0h slot %0d", ncen, mask, val, s); end
  endtask

  task automatic test_reset();
    idle();
    bus.cen = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.slot !== 5'd0)      begin errors++; $display("FAIL reset_slot: got %0d want 0", bus.slot); end
    checks++; if (bus.eg_cnt !== 15'd0)   begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.eg_cnt); end
    checks++; if (bus.rate !== 6'd0)      begin errors++; $display("FAIL reset_rate: got %0d want 0", bus.rate); end
    checks++; if (bus.step !== 1'b0)      begin errors++; $display("FAIL reset_step: got %b want 0", bus.step); end
    checks++; if (bus.eg_out !== 9'd0)    begin errors++; $display("FAIL reset_eg: got %0h want 0", bus.eg_out); end
    checks++; if (bus.out_slot !== 5'd0)  begin errors++; $display("FAIL reset_oslot: got %0d want 0", bus.out_slot); end
    rst = 1'b0;
    ncen = 0;
    repeat (5) tick();
    checks++; if (bus.slot !== 5'd5)      begin errors++; $display("FAIL run_slot: got %0d want 5", bus.slot); end
    rst = 1'b1;
    #1;
    checks++; if (bus.slot !== 5'd0 || bus.out_valid !== 1'b0 || bus.eg_cnt !== 15'd0)
      begin errors++; $display("FAIL midrun_reset: slot=%0d valid=%b cnt=%0d want 0/0/0", bus.slot, bus.out_valid, bus.eg_cnt); end
    tick();
    rst = 1'b0;
    ncen = 0;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.slot !== 5'd1)
      begin errors++; $display("FAIL valid_1cen: valid=%b slot=%0d want 0/1", bus.out_valid, bus.slot); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.slot !== 5'd2)
      begin errors++; $display("FAIL valid_2cen: valid=%b slot=%0d want 1/2", bus.out_valid, bus.slot); end
  endtask

  task automatic test_counter();
    int z = 0;
    wait_pos(0, 0, 17);
    checks++; if (bus.zero !== 1'b0 || bus.eg_cnt !== 15'd0)
      begin errors++; $display("FAIL pre_wrap: zero=%b cnt=%0d want 0/0", bus.zero, bus.eg_cnt); end
    tick();
    checks++; if (bus.zero !== 1'b1 || bus.slot !== 5'd0 || bus.eg_cnt !== 15'd1)
      begin errors++; $display("FAIL post_wrap: zero=%b slot=%0d cnt=%0d want 1/0/1", bus.zero, bus.slot, bus.eg_cnt); end
    repeat (18) begin tick(); if (bus.zero) z++; end
    checks++; if (z != 1 || bus.eg_cnt !== 15'd2)
      begin errors++; $display("FAIL zero_period: pulses=%0d cnt=%0d want 1/2", z, bus.eg_cnt); end
  endtask

  task automatic test_rate();
    logic [4:0] br [7] = '{5'd15, 5'd31, 5'd10, 5'd30, 5'd29, 5'd1, 5'd0};
    logic [3:0] kc [7] = '{4'd15, 4'd15, 4'd13, 4'd0, 4'd1, 4'd0, 4'd7};
    logic       ks [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [5:0] er [7] = '{6'd45, 6'd63, 6'd23, 6'd63, 6'd59, 6'd2, 6'd0};
    int s0 = ncen % 18;
    for (int i = 0; i <= 7; i++) begin
      if (i < 7) drive(DECAY, br[i], kc[i], ks[i], 9'h123);
      else idle();
      tick();
      if (i > 0) begin
        checks++; if (bus.rate !== er[i-1] || bus.out_slot !== 5'((s0 + i - 1) % 18))
          begin errors++; $display("FAIL rate_%0d: rate=%0d slot=%0d want %0d/%0d", i-1, bus.rate, bus.out_slot, er[i-1], (s0 + i - 1) % 18); end
        if (er[i-1] == 6'd0) begin
          checks++; if (bus.step !== 1'b0 || bus.eg_out !== 9'h123)
            begin errors++; $display("FAIL rate0_hold: step=%b eg=%0h want 0/123", bus.step, bus.eg_out); end
        end
      end
    end
  endtask

  task automatic test_attack();
    // eg_cnt odd: rate 63 (FF) and rate 50 (AA, tap eg_cnt[2:0]=3) both step.
    wait_pos(1, 1, 3);
    drive(ATTACK, 5'd31, 4'd0, 1'b0, 9'h1FF); tick();
    drive(ATTACK, 5'd25, 4'd0, 1'b0, 9'h100); tick();
    checks++; if (bus.eg_out !== 9'h000 || bus.step !== 1'b1 || bus.rate !== 6'd63 || bus.out_slot !== 5'd3)
      begin errors++; $display("FAIL atk63: eg=%0h step=%b rate=%0d slot=%0d want 0/1/63/3", bus.eg_out, bus.step, bus.rate, bus.out_slot); end
    drive(ATTACK, 5'd25, 4'd0, 1'b0, 9'h000); tick();
    checks++; if (bus.eg_out !== 9'h0BF || bus.step !== 1'b1 || bus.rate !== 6'd50)
      begin errors++; $display("FAIL atk50: eg=%0h step=%b rate=%0d want BF/1/50", bus.eg_out, bus.step, bus.rate); end
    drive(ATTACK, 5'd25, 4'd0, 1'b0, 9'h003); tick();
    checks++; if (bus.eg_out !== 9'h000 || bus.step !== 1'b1)
      begin errors++; $display("FAIL atk_zero: eg=%0h step=%b want 0/1", bus.eg_out, bus.step); end
    idle(); tick();
    checks++; if (bus.eg_out !== 9'h002 || bus.out_slot !== 5'd6)
      begin errors++; $display("FAIL atk_small: eg=%0h slot=%0d want 2/6", bus.eg_out, bus.out_slot); end

    // eg_cnt[4]=1: rate 24 attack taps eg_cnt[6:4]=1 -> step; rate 48 uses pattern 00.
    wait_pos(16, 16, 7);
    drive(ATTACK, 5'd12, 4'd0, 1'b0, 9'h100); tick();
    drive(ATTACK, 5'd24, 4'd0, 1'b0, 9'h100); tick();
    checks++; if (bus.eg_out !== 9'h0DF || bus.step !== 1'b1 || bus.rate !== 6'd24)
      begin errors++; $display("FAIL atk24: eg=%0h step=%b rate=%0d want DF/1/24", bus.eg_out, bus.step, bus.rate); end
    idle(); tick();
    checks++; if (bus.eg_out !== 9'h100 || bus.step !== 1'b0 || bus.rate !== 6'd48)
      begin errors++; $display("FAIL atk48: eg=%0h step=%b rate=%0d want 100/0/48", bus.eg_out, bus.step, bus.rate); end

    bus.cen = 1'b0;
    drive(ATTACK, 5'd31, 4'd15, 1'b1, 9'h1FF);
    repeat (3) tick();
    checks++; if (bus.slot !== 5'd10 || bus.eg_out !== 9'h100 || bus.rate !== 6'd48 || bus.eg_cnt !== 15'd16)
      begin errors++; $display("FAIL cen_hold: slot=%0d eg=%0h rate=%0d cnt=%0d want 10/100/48/16", bus.slot, bus.eg_out, bus.rate, bus.eg_cnt); end
    idle();
    bus.cen = 1'b1;
  endtask

  task automatic test_back_to_back();
    // eg_cnt[1:0]=3 so rates 53 (88) and 63 (EE) step on tap 3.
    wait_pos(3, 3, 2);
    drive(DECAY,   5'd26, 4'd1,  1'b1, 9'h1FE); tick();
    drive(SUSTAIN, 5'd26, 4'd1,  1'b1, 9'h1FF); tick();
    checks++; if (bus.eg_out !== 9'h1FF || bus.step !== 1'b1 || bus.rate !== 6'd53)
      begin errors++; $display("FAIL dec_sat: eg=%0h step=%b rate=%0d want 1FF/1/53", bus.eg_out, bus.step, bus.rate); end
    drive(RELEASE, 5'd26, 4'd1,  1'b1, 9'h1F0); tick();
    checks++; if (bus.eg_out !== 9'h1FF || bus.step !== 1'b1)
      begin errors++; $display("FAIL sus_hold: eg=%0h step=%b want 1FF/1", bus.eg_out, bus.step); end
    drive(DECAY,   5'd31, 4'd15, 1'b0, 9'h010); tick();
    checks++; if (bus.eg_out !== 9'h1F4 || bus.out_slot !== 5'd4)
      begin errors++; $display("FAIL rel_inc4: eg=%0h slot=%0d want 1F4/4", bus.eg_out, bus.out_slot); end
    idle(); tick();
    checks++; if (bus.eg_out !== 9'h020 || bus.rate !== 6'd63)
      begin errors++; $display("FAIL dec_inc16: eg=%0h rate=%0d want 20/63", bus.eg_out, bus.rate); end
  endtask

  task automatic test_fresh();
    int ns, k;
    // Decay rate 24 taps eg_cnt[7:5]; AA pattern steps on odd taps.
    wait_pos(63, 31, 0);
    drive(DECAY, 5'd12, 4'd0, 1'b0, 9'h010);
    while (ncen < 97 * 18 + 8) begin
      tick();
      ns = ncen - 2;
      k  = ns / 18;
      if (ns % 18 == 5 && (k == 31 || k == 32 || k == 33 || k == 64 || k == 96)) begin
        checks++;
        if (bus.step !== ((k == 32 || k == 96) ? 1'b1 : 1'b0) ||
            bus.eg_out !== ((k == 32 || k == 96) ? 9'h011 : 9'h010) ||
            bus.rate !== 6'd24 || bus.out_slot !== 5'd5)
          begin errors++; $display("FAIL fresh_cnt%0d: step=%b eg=%0h rate=%0d slot=%0d", k, bus.step, bus.eg_out, bus.rate, bus.out_slot); end
      end
    end
    idle();
  endtask

  task automatic test_wrap();
    int n2 = 0;
    bus.cen = 1'b0;
    bus2.cen = 1'b1;
    repeat (2) begin tick(); n2++; end
    checks++; if (bus2.eg_cnt !== 14'd0 || bus2.slot !== 1'b0 || bus2.zero !== 1'b1)
      begin errors++; $display("FAIL presc_hold: cnt=%0d slot=%0d zero=%b want 0/0/1", bus2.eg_cnt, bus2.slot, bus2.zero); end
    repeat (2) begin tick(); n2++; end
    checks++; if (bus2.eg_cnt !== 14'd1 || bus2.out_valid !== 1'b1)
      begin errors++; $display("FAIL presc_tick: cnt=%0d valid=%b want 1/1", bus2.eg_cnt, bus2.out_valid); end
    while (n2 < 65535) begin tick(); n2++; end
    checks++; if (bus2.eg_cnt !== 14'h3FFF)
      begin errors++; $display("FAIL cnt_top: got %0h want 3FFF", bus2.eg_cnt); end
    tick();
    checks++; if (bus2.eg_cnt !== 14'h0000)
      begin errors++; $display("FAIL cnt_wrap: got %0h want 0", bus2.eg_cnt); end
  endtask

  initial begin
    bus.cen = 1'b0;
    idle();
    bus2.cen       = 1'b0;
    bus2.eg_state  = DECAY;
    bus2.base_rate = 5'd0;
    bus2.keycode   = 4'd0;
    bus2.ksr       = 1'b0;
    bus2.eg_in     = 9'd0;
    test_reset();
    test_counter();
    test_rate();
    test_attack();
    test_back_to_back();
    test_fresh();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
